// File: rtl/uart_pkg.sv
// Shared definitions for the framed serial link: field widths, receiver states, checksum.
package uart_pkg;

   localparam int unsigned HDR_W  = 16;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned HALF_W = DATA_W / 2;
   localparam int unsigned CHK_W  = 8;
   localparam int unsigned CNT_W  = 8;

   localparam logic [HDR_W-1:0] HEADER_DEF = 16'hBACD;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      HDR   = 3'd2,
      DATA  = 3'd3,
      CHK   = 3'd4,
      SKIP  = 3'd5
   } rx_state_t;

   typedef struct packed {
      logic [HDR_W-1:0]  hdr;
      logic [HALF_W-1:0] sayi1;
      logic [HALF_W-1:0] sayi2;
      logic [CHK_W-1:0]  chk;
   } frame_t;

   // Only the low byte of each field contributes to the mod-256 sum.
   function automatic logic [CHK_W-1:0] frame_checksum(input logic [CHK_W-1:0] sayi1_lo,
                                                       input logic [CHK_W-1:0] sayi2_lo,
                                                       input logic [CHK_W-1:0] hdr_lo);
      return CHK_W'(sayi1_lo + sayi2_lo + hdr_lo);
   endfunction

endpackage

// File: rtl/uart_rx_bit_tick.sv
// Bit-slot counter: strobes at each mid-bit sample point, restarted on the start edge.
module uart_rx_bit_tick #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick_c
);

   localparam int unsigned    CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
   // First strobe lands floor(CLKS_PER_BIT/2) cycles after the start edge; at 1 clk/bit
   // the counter is stuck at 0 and the strobe is a constant 1.
   localparam logic [CW-1:0]  LOAD = CW'((CLKS_PER_BIT - CLKS_PER_BIT / 2) % CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt_q <= '0;
      else if (restart)        cnt_q <= LOAD;
      else if (cnt_q == LAST)  cnt_q <= '0;
      else                     cnt_q <= cnt_q + CW'(1);
   end

   assign tick_c = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Framed serial receiver: start bit, header, 128 data bits, checksum; no stop bit.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on rx (adds 2 cycles of latency).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned      CLK_FREQ     = 100000000,
   parameter int unsigned      BAUD_RATE    = 115200,
   parameter int unsigned      CLKS_PER_BIT = 1,
   parameter logic [HDR_W-1:0] HEADER       = HEADER_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx,
   output logic [HDR_W-1:0]   baslik_out,
   output logic [HALF_W-1:0]  sayi1_out,
   output logic [HALF_W-1:0]  sayi2_out,
   output logic [CHK_W-1:0]   checksum,
   output logic               frame_valid,
   output logic               chk_err,
   output logic               hdr_err,
   output logic               busy
);

   if (CLK_FREQ == 0 || BAUD_RATE == 0 || CLKS_PER_BIT == 0) begin : g_bad_cfg
      $error("uart_rx_frame: CLK_FREQ, BAUD_RATE and CLKS_PER_BIT must be non-zero");
   end

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], rx};
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = rx;
`endif

   rx_state_t          state_q, state_n;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
   logic [HDR_W-1:0]   hdr_sh_q, hdr_sh_n, hdr_next;
   logic [DATA_W-1:0]  data_sh_q, data_sh_n;
   logic [CHK_W-1:0]   chk_sh_q, chk_sh_n, chk_next;
   frame_t             frame_q, frame_n;
   logic               fv_n, ce_n, he_n;
   logic               restart_c, tick_c;

   uart_rx_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart_c),
      .tick_c  (tick_c)
   );

   // Fields arrive LSB first, so each shifts in from the top.
   assign hdr_next = {rx_s, hdr_sh_q[HDR_W-1:1]};
   assign chk_next = {rx_s, chk_sh_q[CHK_W-1:1]};

   always_comb begin
      state_n   = state_q;
      bit_cnt_n = bit_cnt_q;
      hdr_sh_n  = hdr_sh_q;
      data_sh_n = data_sh_q;
      chk_sh_n  = chk_sh_q;
      frame_n   = frame_q;
      fv_n      = 1'b0;
      ce_n      = 1'b0;
      he_n      = 1'b0;
      restart_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               restart_c = 1'b1;
               bit_cnt_n = '0;
               state_n   = (CLKS_PER_BIT > 1) ? START : HDR;
            end
         end
         START: begin
            if (tick_c) state_n = rx_s ? IDLE : HDR;
         end
         HDR: begin
            if (tick_c) begin
               hdr_sh_n = hdr_next;
               if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
                  bit_cnt_n = '0;
                  if (hdr_next == HEADER) begin
                     state_n = DATA;
                  end else begin
                     state_n = SKIP;
                     he_n    = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         DATA: begin
            if (tick_c) begin
               data_sh_n = {rx_s, data_sh_q[DATA_W-1:1]};
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_n = '0;
                  state_n   = CHK;
               end else begin
                  bit_cnt_n = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         CHK: begin
            if (tick_c) begin
               chk_sh_n = chk_next;
               if (bit_cnt_q == CNT_W'(CHK_W - 1)) begin
                  bit_cnt_n     = '0;
                  state_n       = IDLE;
                  frame_n.hdr   = hdr_sh_q;
                  frame_n.sayi1 = data_sh_q[DATA_W-1:HALF_W];
                  frame_n.sayi2 = data_sh_q[HALF_W-1:0];
                  frame_n.chk   = chk_next;
                  fv_n          = 1'b1;
                  ce_n          = (chk_next != frame_checksum(data_sh_q[HALF_W+CHK_W-1:HALF_W],
                                                              data_sh_q[CHK_W-1:0],
                                                              hdr_sh_q[CHK_W-1:0]));
               end else begin
                  bit_cnt_n = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         SKIP: begin
            if (tick_c) begin
               if (bit_cnt_q == CNT_W'(DATA_W + CHK_W - 1)) begin
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         hdr_sh_q    <= '0;
         data_sh_q   <= '0;
         chk_sh_q    <= '0;
         frame_q     <= '0;
         frame_valid <= 1'b0;
         chk_err     <= 1'b0;
         hdr_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_n;
         bit_cnt_q   <= bit_cnt_n;
         hdr_sh_q    <= hdr_sh_n;
         data_sh_q   <= data_sh_n;
         chk_sh_q    <= chk_sh_n;
         frame_q     <= frame_n;
         frame_valid <= fv_n;
         chk_err     <= ce_n;
         hdr_err     <= he_n;
         busy        <= (state_n != IDLE);
      end
   end

   assign baslik_out = frame_q.hdr;
   assign sayi1_out  = frame_q.sayi1;
   assign sayi2_out  = frame_q.sayi2;
   assign checksum   = frame_q.chk;

endmodule
